// File: rtl/qtree_result_buf.sv
// Credit-managed show-ahead result buffer behind the qtree lookup pipeline.
// Optional hit/miss statistics are built only when QTREE_RESULT_BUF_STATS_EN is defined.
module qtree_result_buf #(
    parameter int ADDR_WIDTH   = 12,
    parameter int BYPASS_WIDTH = 1,
    parameter int DEPTH        = 16,
    parameter int DEPTH_WIDTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_i,
    output logic                    issue_ready_o,
    input  logic                    res_valid_i,
    input  logic                    res_match_i,
    input  logic [ADDR_WIDTH-1:0]   res_addr_i,
    input  logic [BYPASS_WIDTH-1:0] res_bypass_i,
    output logic                    out_valid_o,
    output logic                    out_match_o,
    output logic [ADDR_WIDTH-1:0]   out_addr_o,
    output logic [BYPASS_WIDTH-1:0] out_bypass_o,
    input  logic                    out_ready_i,
    output logic                    overflow_o,
    output logic                    protocol_err_o,
    input  logic                    stats_clr_i,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
);

    localparam int ENTRY_W = 1 + ADDR_WIDTH + BYPASS_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   DEPTH_C  = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH+1:0] DEPTH_CW = (DEPTH_WIDTH+2)'(DEPTH);

    logic [ENTRY_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH:0]   fill_q, fill_d, inflight_q, inflight_d;
    logic                   overflow_q, overflow_d, perr_q, perr_d;
    logic                   valid_s, full_s, pop_s, wr_en_s, drop_s, ready_s;
    logic [ENTRY_W-1:0]     head_s;

    assign valid_s = (fill_q != '0);
    assign full_s  = (fill_q == DEPTH_C);
    assign pop_s   = valid_s & out_ready_i;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign wr_en_s = res_valid_i & (~full_s | pop_s);
    assign drop_s  = res_valid_i & full_s & ~pop_s;
    assign ready_s = (({1'b0, fill_q} + {1'b0, inflight_q}) < DEPTH_CW);
    assign head_s  = mem_q[rd_ptr_q];

    assign issue_ready_o  = ready_s;
    assign out_valid_o    = valid_s;
    assign out_match_o    = valid_s ? head_s[ENTRY_W-1] : 1'b0;
    assign out_addr_o     = valid_s ? head_s[ENTRY_W-2 -: ADDR_WIDTH] : '0;
    assign out_bypass_o   = valid_s ? head_s[BYPASS_WIDTH-1:0] : '0;
    assign overflow_o     = overflow_q;
    assign protocol_err_o = perr_q;

    // Next-state for pointers, fill, inflight credit and sticky error flags.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q + (DEPTH_WIDTH+1)'(wr_en_s) - (DEPTH_WIDTH+1)'(pop_s);
        inflight_d = inflight_q;
        overflow_d = overflow_q | drop_s;
        perr_d     = perr_q;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({issue_i, res_valid_i})
            2'b10: begin
                perr_d = perr_q | ~ready_s;
                if (inflight_q != '1) begin
                    inflight_d = inflight_q + (DEPTH_WIDTH+1)'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            2'b01: begin
                if (inflight_q == '0) begin
                    perr_d     = 1'b1;
                    inflight_d = inflight_q;
                end else begin
                    inflight_d = inflight_q - (DEPTH_WIDTH+1)'(1);
                end
            end
            2'b11: begin
                perr_d = perr_q | ~ready_s;
            end
            default: begin
                inflight_d = inflight_q;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
        end
    end

    // Entry storage; stale contents are masked by the valid gating on out_*.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {res_match_i, res_addr_i, res_bypass_i};
        end
    end

`ifdef QTREE_RESULT_BUF_STATS_EN
    logic [31:0] hit_q, hit_d, miss_q, miss_d;

    // Saturating hit/miss counters over accepted entries; clear wins.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (stats_clr_i) begin
            hit_d  = 32'd0;
            miss_d = 32'd0;
        end else if (wr_en_s && res_match_i && (hit_q != 32'hFFFF_FFFF)) begin
            hit_d  = hit_q + 32'd1;
        end else if (wr_en_s && !res_match_i && (miss_q != 32'hFFFF_FFFF)) begin
            miss_d = miss_q + 32'd1;
        end else begin
            hit_d  = hit_q;
            miss_d = miss_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_cnt_o  = hit_q;
    assign miss_cnt_o = miss_q;
`else
    logic unused_stats_clr_s;
    assign unused_stats_clr_s = stats_clr_i;
    assign hit_cnt_o          = 32'd0;
    assign miss_cnt_o         = 32'd0;
`endif

endmodule

// File: tb/tb_qtree_result_buf.sv
// Scoreboard bench for qtree_result_buf at DEPTH=4; statistics expectations follow QTREE_RESULT_BUF_STATS_EN.
module tb_qtree_result_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue = 1'b0, issue_ready;
    logic        res_valid = 1'b0, res_match = 1'b0;
    logic [11:0] res_addr = 12'd0;
    logic [0:0]  res_bypass = 1'b0;
    logic        out_valid, out_match;
    logic [11:0] out_addr;
    logic [0:0]  out_bypass;
    logic        out_ready = 1'b0;
    logic        overflow, perr;
    logic        stats_clr = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [13:0] sb_q[$];
    int          m_infl = 0;
    logic        m_ovf = 1'b0, m_perr = 1'b0;
    int          m_hit = 0, m_miss = 0;

    always #5 clk = ~clk;

    qtree_result_buf #(
        .ADDR_WIDTH(12), .BYPASS_WIDTH(1), .DEPTH(4), .DEPTH_WIDTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_i(issue), .issue_ready_o(issue_ready),
        .res_valid_i(res_valid), .res_match_i(res_match),
        .res_addr_i(res_addr), .res_bypass_i(res_bypass),
        .out_valid_o(out_valid), .out_match_o(out_match),
        .out_addr_o(out_addr), .out_bypass_o(out_bypass),
        .out_ready_i(out_ready),
        .overflow_o(overflow), .protocol_err_o(perr),
        .stats_clr_i(stats_clr),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_hit();
`ifdef QTREE_RESULT_BUF_STATS_EN
        return 32'(m_hit);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_miss();
`ifdef QTREE_RESULT_BUF_STATS_EN
        return 32'(m_miss);
`else
        return 32'd0;
`endif
    endfunction

    // One clock: compare at negedge, advance the model, return 1 time unit after posedge.
    task automatic tick();
        logic pop, acc, rdy;
        @(negedge clk);
        rdy = ((sb_q.size() + m_infl) < 4);
        check("out_valid", out_valid, (sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check("out_match", out_match, sb_q[0][13]);
            check("out_addr", out_addr, sb_q[0][12:1]);
            check("out_bypass", out_bypass, sb_q[0][0]);
        end
        check("issue_ready", issue_ready, rdy);
        check("overflow", overflow, m_ovf);
        check("protocol_err", perr, m_perr);
        check("hit_cnt", hit_cnt, exp_hit());
        check("miss_cnt", miss_cnt, exp_miss());
        if (!rst) begin
            pop = (sb_q.size() != 0) && out_ready;
            acc = res_valid && ((sb_q.size() < 4) || pop);
            if (pop) void'(sb_q.pop_front());
            if (acc) sb_q.push_back({res_match, res_addr, res_bypass});
            if (res_valid && !acc) m_ovf = 1'b1;
            if (issue && !rdy) m_perr = 1'b1;
            if (res_valid && !issue && m_infl == 0) m_perr = 1'b1;
            if (issue && !res_valid) m_infl = (m_infl == 7) ? 7 : m_infl + 1;
            else if (res_valid && !issue && m_infl != 0) m_infl = m_infl - 1;
            if (stats_clr) begin
                m_hit = 0;
                m_miss = 0;
            end else if (acc && res_match) m_hit++;
            else if (acc) m_miss++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_infl = 0;
        m_ovf = 1'b0;
        m_perr = 1'b0;
        m_hit = 0;
        m_miss = 0;
    endtask

    task automatic do_reset();
        issue = 1'b0; res_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_match", out_match, 1'b0);
        check("rst_addr", out_addr, 12'd0);
        check("rst_bypass", out_bypass, 1'b0);
        check("rst_ready", issue_ready, 1'b1);
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_res(input logic m, input logic [11:0] a, input logic b);
        res_valid = 1'b1; res_match = m; res_addr = a; res_bypass = b;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue = 1'b1;
            tick();
        end
        issue = 1'b0;
    endtask

    initial begin
        do_reset();

        // Pass-through with 1-cycle write-to-valid latency.
        out_ready = 1'b1;
        issue_n(1);
        send_res(1'b1, 12'h02A, 1'b1);
        check("pt_valid_n1", out_valid, 1'b1);
        check("pt_addr_n1", out_addr, 12'h02A);
        check("pt_match_n1", out_match, 1'b1);
        check("pt_bypass_n1", out_bypass, 1'b1);
        tick();
        check("pt_valid_n2", out_valid, 1'b0);
        tick();

        // Credit stall, then full with simultaneous pop.
        do_reset();
        issue_n(4);
        check("stall_ready", issue_ready, 1'b0);
        for (int i = 0; i < 4; i++) send_res(i[0], 12'(12'h010 + i), ~i[0]);
        tick();
        check("stall_full_valid", out_valid, 1'b1);
        check("stall_ovf", overflow, 1'b0);
        out_ready = 1'b1;
        send_res(1'b1, 12'h100, 1'b0);
        check("fullpop_ovf", overflow, 1'b0);
        check("fullpop_head", out_addr, 12'h011);
        for (int i = 0; i < 5; i++) tick();
        check("fullpop_drained", out_valid, 1'b0);

        // Forced overflow: 5th result into a full FIFO with no pop.
        do_reset();
        issue_n(4);
        for (int i = 0; i < 4; i++) send_res(i < 2, 12'(12'h020 + i), 1'b0);
        send_res(1'b1, 12'h0FF, 1'b1);
        check("ovf_set", overflow, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_hits", hit_cnt, exp_hit());
        check("ovf_misses", miss_cnt, exp_miss());

        // Protocol errors: orphan result, then issue without credit.
        do_reset();
        send_res(1'b0, 12'h005, 1'b0);
        check("perr_orphan", perr, 1'b1);
        tick();
        do_reset();
        issue_n(5);
        check("perr_noready", perr, 1'b1);
        tick();

        // Statistics: 3 hits, 2 misses, then clear coinciding with a hit.
        do_reset();
        out_ready = 1'b1;
        issue_n(5);
        for (int i = 0; i < 5; i++) send_res((i == 0) || (i == 1) || (i == 3), 12'(12'h040 + i), 1'b0);
        tick();
        check("stats_hit3", hit_cnt, exp_hit());
        check("stats_miss2", miss_cnt, exp_miss());
        issue_n(1);
        stats_clr = 1'b1;
        send_res(1'b1, 12'h050, 1'b1);
        stats_clr = 1'b0;
        tick();
        check("stats_clr_hit", hit_cnt, 32'd0);
        check("stats_clr_miss", miss_cnt, 32'd0);

        // Reset mid-operation discards entries and credit.
        do_reset();
        issue_n(2);
        send_res(1'b1, 12'h060, 1'b0);
        send_res(1'b0, 12'h061, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ready", issue_ready, 1'b1);
        model_clear();
        tick();
        rst = 1'b0;
        send_res(1'b1, 12'h070, 1'b0);
        check("midrst_perr", perr, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qtree_result_buf.md
QTREE_RESULT_BUF -- requirements
Module: qtree_result_buf

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, which is the width of the lookup result address.
REQ-002 SHALL have parameter BYPASS_WIDTH, default 1, which is the width of the per-lookup sideband.
REQ-003 SHALL have parameter DEPTH, default 16, which is the number of FIFO entries; legal values are powers of 2 that are at least 2.
REQ-004 SHALL have parameter DEPTH_WIDTH, default 4, which equals log2(DEPTH).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port issue_i, input, 1 bit: a lookup entered the tree pipeline this cycle (driven from lookup_valid_i).
REQ-008 SHALL have port issue_ready_o, output, 1 bit: the upstream may issue a lookup this cycle.
REQ-009 SHALL have port res_valid_i, input, 1 bit: tree result valid (from lookup_valid_o).
REQ-010 SHALL have port res_match_i, input, 1 bit: the tree result matched.
REQ-011 SHALL have port res_addr_i, input, ADDR_WIDTH bits: the tree result address.
REQ-012 SHALL have port res_bypass_i, input, BYPASS_WIDTH bits: the tree result sideband.
REQ-013 SHALL have ports out_valid_o, out_match_o, out_addr_o and out_bypass_o, all outputs, with widths 1, 1, ADDR_WIDTH and BYPASS_WIDTH: the buffered result.
REQ-014 SHALL have port out_ready_i, input, 1 bit: the consumer accepts the buffered result.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky flag, a result was dropped.
REQ-016 SHALL have port protocol_err_o, output, 1 bit: sticky flag, credit protocol violated.
REQ-017 SHALL have port stats_clr_i, input, 1 bit: synchronous clear of the statistics counters.
REQ-018 SHALL have ports hit_cnt_o and miss_cnt_o, outputs, 32 bits each: the statistics counters.

Function
REQ-019 SHALL be a show-ahead FIFO of {match, addr, bypass}; a pop occurs when out_valid_o and out_ready_i are both 1.
REQ-020 SHALL write an entry on res_valid_i when fill < DEPTH, and the entry SHALL be visible on out_* no earlier than the next cycle (1-cycle write-to-valid latency).
REQ-021 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle; fill is then unchanged.
REQ-022 SHALL drop the result when res_valid_i arrives while full with no pop, and SHALL set overflow_o.
REQ-023 SHALL hold out_* stable while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL maintain read and write pointers of DEPTH_WIDTH bits that wrap modulo DEPTH, plus a fill counter of DEPTH_WIDTH+1 bits.
REQ-025 SHALL maintain an inflight counter of DEPTH_WIDTH+1 bits: +1 on issue_i, -1 on res_valid_i, unchanged when both occur in the same cycle.
REQ-026 SHALL drive issue_ready_o = (fill + inflight < DEPTH), decoded combinationally from registers only.
REQ-027 SHALL, on issue_i while issue_ready_o=0, set protocol_err_o and still count the issue, with inflight saturating at 2^(DEPTH_WIDTH+1)-1.
REQ-028 SHALL, on res_valid_i while inflight=0 with no simultaneous issue_i, set protocol_err_o and keep inflight at 0; the result is still written if space allows.
REQ-029 SHALL keep overflow_o and protocol_err_o set until reset.
REQ-030 SHALL count credit correctly: with compliant upstream behaviour the FIFO never overflows.

Reset
REQ-031 SHALL, on rst_i=1, immediately clear the pointers, fill, inflight, out_valid_o, overflow_o, protocol_err_o, hit_cnt_o and miss_cnt_o; out_match_o, out_addr_o and out_bypass_o SHALL read 0.
REQ-032 SHALL drive issue_ready_o=1 one clock-independent settling after reset, since fill=0 and inflight=0.
REQ-033 SHALL discard buffered entries and clear the inflight count on reset mid-operation; results that arrive afterwards count as protocol errors per REQ-028.

Configuration
REQ-034 SHALL compile the statistics counters in only when macro QTREE_RESULT_BUF_STATS_EN is defined.
REQ-035 SHALL, with QTREE_RESULT_BUF_STATS_EN defined, increment hit_cnt_o on each written entry with match=1 and miss_cnt_o on each written entry with match=0.
REQ-036 SHALL not count dropped results, and SHALL saturate each counter at 2^32-1.
REQ-037 SHALL give stats_clr_i priority over a same-cycle increment.
REQ-038 SHALL, without QTREE_RESULT_BUF_STATS_EN, tie hit_cnt_o and miss_cnt_o to 0, ignore stats_clr_i and instantiate no counter registers.

Verification
REQ-039 SHALL cover credit stall: DEPTH=4, out_ready_i=0, issue 4 lookups -> issue_ready_o=0 after the 4th; after the results arrive, fill=4 and overflow_o=0.
REQ-040 SHALL cover pass-through: a single result with match=1, addr=0x2A and bypass=1 at cycle N, with out_ready_i=1 -> out_valid_o=1 at N+1 with the same fields, and out_valid_o=0 at N+2.
REQ-041 SHALL cover full with simultaneous pop: DEPTH=4 and full, res_valid_i and a pop in the same cycle -> fill stays 4, order is preserved and overflow_o=0.
REQ-042 SHALL cover forced overflow: a 5th result into a full DEPTH=4 FIFO with no pop -> the result is dropped, overflow_o=1 and stays 1, and hit/miss counts are unchanged.
REQ-043 SHALL cover protocol errors: res_valid_i with inflight=0 -> protocol_err_o=1 and inflight=0; issue_i while issue_ready_o=0 -> protocol_err_o=1.
REQ-044 SHALL cover statistics with QTREE_RESULT_BUF_STATS_EN defined: 3 hits, 2 misses, then stats_clr_i coinciding with a hit -> counts 3/2 and then 0/0; with the macro undefined, both counts remain 0.
